arcade_input_mapper: RTL
========================

# arcade_input_mapper

Parametrised player-input front end for the arcade cores. It merges PS/2 keyboard events and HPS joystick words into per-player active-low control buses. It stretches coin pulses to a guaranteed minimum width and captures DIP-switch banks and the ROM-variant byte from the ioctl stream. It sits between `hps_io` and the game top-level and replaces the hand-written keyboard/joystick/DIP logic of each core.

## Interface
Parameters:
- `PLAYERS`, 2 — player count, 1..4.
- `BUTTONS`, 2 — action buttons per player, 1..2; joystick bits `4..3+BUTTONS`.
- `START_BIT`, 6 — joystick bit carrying that player's start.
- `COIN_BIT`, 7 — joystick bit carrying that player's coin.
- `DIP_BANKS`, 2 — 8-bit DIP banks, 1..8.
- `COIN_PULSE`, 16'd4096 — minimum coin assertion in clocks, ≥1.
- `AUTOFIRE_DIV`, 20'd400000 — autofire half-period in clocks (used only with `AUTOFIRE_EN`).

Ports:
- `clk_49m` in 1 — single clock for everything.
- `reset` in 1 — **one clock; reset is asynchronous and active-low.**
- `ps2_key` in 11 — [10] event toggle, [9] pressed, [7:0] scan code.
- `joystick` in 16*PLAYERS — player p in `[16p+15:16p]`; [0]R [1]L [2]D [3]U.
- `autofire` in PLAYERS — per-player autofire request.
- `ioctl_wr` in 1, `ioctl_index` in 8, `ioctl_addr` in 25, `ioctl_dout` in 8 — download bus.
- `p_joystick` out 4*PLAYERS — active-low {R,L,D,U} per player.
- `p_buttons` out BUTTONS*PLAYERS — active-low; button 0 in the LSB of each player's slice.
- `start_n` out PLAYERS — active-low.
- `coin_n` out PLAYERS — active-low, stretched.
- `service_n` out 1 — active-low.
- `dip_sw` out 8*DIP_BANKS — inverted stored bytes; bank 0 in [7:0].
- `variant` out 8 — ROM-variant byte.

## Operation
- Keyboard event detection:
  - `ps2_key[10]` is registered each clock.
  - A difference from its previous value is one event.
  - On an event, the key register matching `ps2_key[7:0]` loads `ps2_key[9]`. Bit 8 is ignored.
- Player 0 key map: 75 up, 72 down, 6B left, 74 right, 14 button 0, 11 button 1.
- Player 1 key map (only if `PLAYERS`≥2): 2D up, 2B down, 23 left, 34 right, 1C button 0, 1B button 1.
- Key map for starts, coins and service: 16 start0, 1E start1, 2E coin0, 36 coin1, 46 service.
- Players 2–3 have no keyboard map.
- Each logical input is (key register OR the matching joystick bit), and the output is its registered complement.
- Coin stretcher, one per player:
  - `prev` holds the combined coin level from the previous clock.
  - On a rising edge, the 16-bit counter loads `COIN_PULSE-1`.
  - `coin_n` is low while the level is high or the counter is nonzero.
  - The counter decrements to 0 and saturates there.
  - A new rising edge during a stretch reloads the counter.
- DIP capture:
  - Trigger: `ioctl_wr && ioctl_index==254 && ioctl_addr < DIP_BANKS`.
  - Action: writes `ioctl_dout` to bank `ioctl_addr`.
  - Writes at higher addresses are dropped.
- Variant capture: `ioctl_wr && ioctl_index==1 && ioctl_addr==0` loads `variant`.
- Reset values:
  - Key registers, toggle history, coin counters and `prev` clear to 0.
  - `p_joystick`, `p_buttons`, `start_n`, `coin_n` and `service_n` reset to all 1s.
- DIP banks and `variant` are excluded from `reset`:
  - They are power-up initialised to 0 (`dip_sw` all 1s, `variant` 0).
  - They survive OSD/user resets, because downloads occur only once.

## Timing
- Joystick bit to output: 1 clock.
- `ps2_key[10]` toggle to output: 2 clocks (key register, then output register).
- Coin: output falls 1 clock after the level rises.
- Coin pulse width: max(`COIN_PULSE`, held time + 1) clocks.
- ioctl capture: `dip_sw`/`variant` update 1 clock after the qualifying `ioctl_wr` cycle.
- Simultaneous events:
  - Keyboard and joystick for the same input: OR'd, with no priority.
  - A `ps2_key` event and a coin edge in the same clock are handled independently.
- Reset asserted mid-stretch: the counter clears immediately and `coin_n` goes to 1 asynchronously.
- Release of reset: synchronous to `clk_49m` through a 2-flop deassertion stage inside the block.

## Configuration
- `ARCADE_INPUT_AUTOFIRE_EN` defined:
  - Adds a 20-bit shared prescaler; each wrap of the prescaler toggles a per-player phase bit.
  - While `autofire[p]` is 1 and button 0 is held, button 0's output follows the phase bit.
  - The phase is forced to "pressed" on the press edge, so the first shot is immediate.
  - Releasing the button returns the output to 1 on the next clock.
- Not defined: `autofire` is ignored, `AUTOFIRE_DIV` is unused, and button 0 passes through.

## Test plan
- Arrow keys: toggle `ps2_key[10]` with code 75, pressed=1 → `p_joystick[0]` goes 0 two clocks later; repeat with pressed=0 → returns to 1.
- Coin: `joystick[7]` high for 3 clocks with `COIN_PULSE`=16 → `coin_n[0]` low for exactly 16 clocks. Held for 40 clocks → low for 41 clocks.
- Coin retrigger: second rising edge 10 clocks into a 16-clock stretch → total low time 26 clocks.
- DIP: index 254 writes A5@0, 3C@1, FF@2 with `DIP_BANKS`=2 → `dip_sw`=16'hC35A; the addr 2 write has no effect. Pulsing `reset` afterward leaves `dip_sw` unchanged.
- Reset mid-press: hold key 14 and joystick fire, assert `reset` → all outputs read 1s asynchronously. After release, outputs follow the joystick only; key state is cleared.
- Autofire with macro, `AUTOFIRE_DIV`=8, `autofire[0]`=1, button held → `p_buttons[0]` starts at 0 the clock after the press, then toggles every 8 clocks.

Source files
------------

// File: rtl/arcade_input_mapper_if.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_mapper_if
// Description : ioctl download bus from hps_io to the arcade input mapper.
//               master = hps_io side (drives), slave = mapper side (samples).
//               Members: ioctl_wr (write strobe), ioctl_index (stream id),
//               ioctl_addr (byte address), ioctl_dout (byte data).
// Revision    : 1.0 - initial release
// ============================================================================
interface arcade_input_mapper_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_wr,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input ioctl_wr,
        input ioctl_index,
        input ioctl_addr,
        input ioctl_dout
    );
endinterface
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_mapper
// Description : Player-input front end. Merges PS/2 key events and HPS
//               joystick words into per-player active-low control buses,
//               stretches coin pulses, captures DIP banks and the ROM-variant
//               byte from the ioctl stream.
// Ports       : clk_49m     - single clock
//               reset       - asynchronous active-low reset (release is
//                             resynchronised internally)
//               ps2_key     - [10] toggle, [9] pressed, [7:0] scan code
//               joystick    - 16 bits per player ([0]R [1]L [2]D [3]U)
//               autofire    - per-player autofire request
//               ioctl       - download bus (slave modport)
//               p_joystick  - active-low {R,L,D,U} per player
//               p_buttons   - active-low buttons, button 0 in slice LSB
//               start_n / coin_n / service_n - active-low
//               dip_sw      - inverted DIP bytes, bank 0 in [7:0]
//               variant     - ROM-variant byte
// Options     : ARCADE_INPUT_AUTOFIRE_EN - enables autofire on button 0
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter int          BUTTONS      = 2,
    parameter int          START_BIT    = 6,
    parameter int          COIN_BIT     = 7,
    parameter int          DIP_BANKS    = 2,
    parameter logic [15:0] COIN_PULSE   = 16'd4096,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  wire logic                         clk_49m,
    input  wire logic                         reset,
    input  wire logic [10:0]                  ps2_key,
    input  wire logic [16*PLAYERS-1:0]        joystick,
    input  wire logic [PLAYERS-1:0]           autofire,
    arcade_input_mapper_if.slave              ioctl,
    output logic      [4*PLAYERS-1:0]         p_joystick,
    output logic      [BUTTONS*PLAYERS-1:0]   p_buttons,
    output logic      [PLAYERS-1:0]           start_n,
    output logic      [PLAYERS-1:0]           coin_n,
    output logic                              service_n,
    output logic      [8*DIP_BANKS-1:0]       dip_sw,
    output logic      [7:0]                   variant
);

    // Key register slots: 6 per keyboard player (U,D,L,R,B0,B1), then
    // start0/1, coin0/1 and service.
    localparam int c_NUM_KEYS  = 17;
    localparam int c_K_START0  = 12;
    localparam int c_K_COIN0   = 14;
    localparam int c_K_SERVICE = 16;

    // ------------------------------------------------------------------
    // Reset: assertion is asynchronous, release passes two flops.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Keyboard event decode
    // ------------------------------------------------------------------
    logic                  r_ps2_tog;
    logic [c_NUM_KEYS-1:0] r_keys;
    logic [4:0]            w_key_idx;
    logic                  w_key_valid;
    logic                  w_ps2_event;

    always_comb begin
        w_key_valid = 1'b1;
        w_key_idx   = 5'd0;
        case (ps2_key[7:0])
            8'h75:   w_key_idx = 5'd0;
            8'h72:   w_key_idx = 5'd1;
            8'h6B:   w_key_idx = 5'd2;
            8'h74:   w_key_idx = 5'd3;
            8'h14:   w_key_idx = 5'd4;
            8'h11:   w_key_idx = 5'd5;
            8'h2D:   w_key_idx = 5'd6;
            8'h2B:   w_key_idx = 5'd7;
            8'h23:   w_key_idx = 5'd8;
            8'h34:   w_key_idx = 5'd9;
            8'h1C:   w_key_idx = 5'd10;
            8'h1B:   w_key_idx = 5'd11;
            8'h16:   w_key_idx = 5'd12;
            8'h1E:   w_key_idx = 5'd13;
            8'h2E:   w_key_idx = 5'd14;
            8'h36:   w_key_idx = 5'd15;
            8'h46:   w_key_idx = 5'd16;
            default: w_key_valid = 1'b0;
        endcase
    end

    // Any change of the toggle bit is one key event.
    assign w_ps2_event = ps2_key[10] ^ r_ps2_tog;

    always_ff @(posedge clk_49m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ps2_tog <= 1'b0;
            r_keys    <= '0;
        end else begin
            r_ps2_tog <= ps2_key[10];
            if (w_ps2_event && w_key_valid) begin
                r_keys[w_key_idx] <= ps2_key[9];
            end
        end
    end

    // ------------------------------------------------------------------
    // Service key
    // ------------------------------------------------------------------
    logic r_service_n;

    always_ff @(posedge clk_49m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_service_n <= 1'b1;
        end else begin
            r_service_n <= ~r_keys[c_K_SERVICE];
        end
    end

    assign service_n = r_service_n;

    // ------------------------------------------------------------------
    // Shared autofire prescaler
    // ------------------------------------------------------------------
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] r_af_pre;
    logic        w_af_wrap;

    assign w_af_wrap = (r_af_pre == AUTOFIRE_DIV - 20'd1);

    always_ff @(posedge clk_49m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_af_pre <= 20'd0;
        end else begin
            r_af_pre <= w_af_wrap ? 20'd0 : r_af_pre + 20'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-player merge, coin stretch and output registers
    // ------------------------------------------------------------------
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0]        w_joy;
        logic [5:0]         w_kp;
        logic               w_kstart;
        logic               w_kcoin;
        logic               w_up, w_down, w_left, w_right;
        logic               w_start, w_coin;
        logic [BUTTONS-1:0] w_btn;
        logic [BUTTONS-1:0] w_btn_eff;
        logic [3:0]         r_joy_n;
        logic [BUTTONS-1:0] r_btn_n;
        logic               r_start_n;
        logic               r_coin_n;
        logic               r_coin_prev;
        logic [15:0]        r_coin_cnt;

        assign w_joy = joystick[16*p +: 16];

        // Only players 0 and 1 have a keyboard map.
        if (p < 2) begin : g_kbd
            assign w_kp     = r_keys[6*p +: 6];
            assign w_kstart = r_keys[c_K_START0 + p];
            assign w_kcoin  = r_keys[c_K_COIN0 + p];
        end else begin : g_nokbd
            assign w_kp     = 6'd0;
            assign w_kstart = 1'b0;
            assign w_kcoin  = 1'b0;
        end

        assign w_up    = w_kp[0] | w_joy[3];
        assign w_down  = w_kp[1] | w_joy[2];
        assign w_left  = w_kp[2] | w_joy[1];
        assign w_right = w_kp[3] | w_joy[0];
        assign w_start = w_kstart | w_joy[START_BIT];
        assign w_coin  = w_kcoin  | w_joy[COIN_BIT];

        for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            assign w_btn[b] = w_kp[4+b] | w_joy[4+b];
            if (b == 0) begin : g_b0
`ifdef ARCADE_INPUT_AUTOFIRE_EN
                logic r_b0_prev;
                logic r_af_phase;
                logic w_b0_edge;

                assign w_b0_edge = w_btn[0] & ~r_b0_prev;

                // The press edge forces the "fire" phase so the first shot
                // is not delayed by the free-running prescaler.
                always_ff @(posedge clk_49m or negedge w_rst_n) begin
                    if (!w_rst_n) begin
                        r_b0_prev  <= 1'b0;
                        r_af_phase <= 1'b0;
                    end else begin
                        r_b0_prev <= w_btn[0];
                        if (w_b0_edge) begin
                            r_af_phase <= 1'b1;
                        end else if (w_af_wrap) begin
                            r_af_phase <= ~r_af_phase;
                        end
                    end
                end

                assign w_btn_eff[0] = autofire[p]
                                    ? (w_btn[0] & (w_b0_edge | r_af_phase))
                                    : w_btn[0];
`else
                assign w_btn_eff[0] = w_btn[0];
`endif
            end else begin : g_bn
                assign w_btn_eff[b] = w_btn[b];
            end
        end

        // r_coin_prev is part of the low condition so a long hold keeps
        // coin_n low one clock past the release (width = held + 1).
        always_ff @(posedge clk_49m or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_joy_n     <= 4'hF;
                r_btn_n     <= '1;
                r_start_n   <= 1'b1;
                r_coin_n    <= 1'b1;
                r_coin_prev <= 1'b0;
                r_coin_cnt  <= 16'd0;
            end else begin
                r_joy_n     <= ~{w_right, w_left, w_down, w_up};
                r_btn_n     <= ~w_btn_eff;
                r_start_n   <= ~w_start;
                r_coin_prev <= w_coin;
                if (w_coin && !r_coin_prev) begin
                    r_coin_cnt <= COIN_PULSE - 16'd1;
                end else if (r_coin_cnt != 16'd0) begin
                    r_coin_cnt <= r_coin_cnt - 16'd1;
                end
                r_coin_n <= ~(w_coin | r_coin_prev | (r_coin_cnt != 16'd0));
            end
        end

        assign p_joystick[4*p +: 4]             = r_joy_n;
        assign p_buttons[BUTTONS*p +: BUTTONS] = r_btn_n;
        assign start_n[p]                       = r_start_n;
        assign coin_n[p]                        = r_coin_n;
    end

    // ------------------------------------------------------------------
    // ioctl capture. Deliberately outside reset: downloads happen once at
    // load time and must survive OSD/user resets.
    // ------------------------------------------------------------------
    logic [8*DIP_BANKS-1:0] r_dip     = '0;
    logic [7:0]             r_variant = 8'h00;

    always_ff @(posedge clk_49m) begin
        if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd254) begin
            for (int b = 0; b < DIP_BANKS; b++) begin
                if (ioctl.ioctl_addr == 25'(b)) begin
                    r_dip[8*b +: 8] <= ioctl.ioctl_dout;
                end
            end
        end
        if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd1 &&
            ioctl.ioctl_addr == 25'd0) begin
            r_variant <= ioctl.ioctl_dout;
        end
    end

    assign dip_sw  = ~r_dip;
    assign variant = r_variant;

    // Inputs that are legitimately unused in some configurations.
    logic w_unused;
    assign w_unused = ^{ps2_key[8], joystick, autofire, AUTOFIRE_DIV};

endmodule
`default_nettype wire
